// File: rtl/march_bist_if.sv
// March BIST controller bus.
// Groups the wrapper-side controls (start, mode, bg), the SRAM port
// (rdata in; addr, wdata, we, re out) and the status outputs
// (busy, done, fail, fail_addr, fail_elem, fail_count).
// master: environment side (wrapper registers + SRAM model).
// slave : the controller.
interface march_bist_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [1:0]        mode;
  logic [DATA_W-1:0] bg;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic              re;
  logic              busy;
  logic              done;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;
  logic [CNT_W-1:0]  fail_count;

  modport master (
    output start, mode, bg, rdata,
    input  addr, wdata, we, re, busy, done, fail, fail_addr, fail_elem, fail_count
  );

  modport slave (
    input  start, mode, bg, rdata,
    output addr, wdata, we, re, busy, done, fail, fail_addr, fail_elem, fail_count
  );
endinterface

// File: rtl/march_bist_ctrl.sv
// March-algorithm BIST controller for a single-port synchronous SRAM.
// Runs MATS+ (mode 0), March C- (mode 1) or March LR (mode 2) over all
// 2^ADDR_W addresses using a latched data background, compares read data
// two cycles after each read op and keeps sticky pass/fail status.
// Ports: clk, rst_n (async, active-low), bus (march_bist_if.slave):
//   start/mode/bg/rdata in; addr/wdata/we/re/busy/done/fail/fail_addr/
//   fail_elem/fail_count out. All outputs are registered.
module march_bist_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  march_bist_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Op encoding {is_write, value}; value 0 = bg, 1 = ~bg.
  localparam logic [1:0] R0 = 2'b00;
  localparam logic [1:0] R1 = 2'b01;
  localparam logic [1:0] W0 = 2'b10;
  localparam logic [1:0] W1 = 2'b11;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef struct packed {
    logic       down;       // descending address order
    logic [1:0] last_op;    // index of the final op in the element
    logic       last_elem;  // final element of the algorithm
    logic [7:0] ops;        // op k lives in ops[2k+1:2k]
  } elem_t;

  function automatic elem_t mk(input logic dn, input logic [1:0] lo, input logic le,
                               input logic [1:0] o0, input logic [1:0] o1,
                               input logic [1:0] o2, input logic [1:0] o3);
    return '{dn, lo, le, {o3, o2, o1, o0}};
  endfunction

  function automatic elem_t elem_info(input logic [1:0] m, input logic [2:0] e);
    elem_t t;
    case ({m, e})
      // MATS+
      {2'd0, 3'd0}: t = mk(1'b0, 2'd0, 1'b0, W0, W0, W0, W0);
      {2'd0, 3'd1}: t = mk(1'b0, 2'd1, 1'b0, R0, W1, W0, W0);
      {2'd0, 3'd2}: t = mk(1'b1, 2'd1, 1'b1, R1, W0, W0, W0);
      // March C-
      {2'd1, 3'd0}: t = mk(1'b0, 2'd0, 1'b0, W0, W0, W0, W0);
      {2'd1, 3'd1}: t = mk(1'b0, 2'd1, 1'b0, R0, W1, W0, W0);
      {2'd1, 3'd2}: t = mk(1'b0, 2'd1, 1'b0, R1, W0, W0, W0);
      {2'd1, 3'd3}: t = mk(1'b1, 2'd1, 1'b0, R0, W1, W0, W0);
      {2'd1, 3'd4}: t = mk(1'b1, 2'd1, 1'b0, R1, W0, W0, W0);
      {2'd1, 3'd5}: t = mk(1'b0, 2'd0, 1'b1, R0, W0, W0, W0);
      // March LR
      {2'd2, 3'd0}: t = mk(1'b0, 2'd0, 1'b0, W0, W0, W0, W0);
      {2'd2, 3'd1}: t = mk(1'b1, 2'd1, 1'b0, R0, W1, W0, W0);
      {2'd2, 3'd2}: t = mk(1'b0, 2'd3, 1'b0, R1, W0, R0, W1);
      {2'd2, 3'd3}: t = mk(1'b0, 2'd1, 1'b0, R1, W0, W0, W0);
      {2'd2, 3'd4}: t = mk(1'b0, 2'd3, 1'b0, R0, W1, R1, W0);
      {2'd2, 3'd5}: t = mk(1'b0, 2'd0, 1'b1, R0, W0, W0, W0);
      default:      t = mk(1'b0, 2'd0, 1'b1, W0, W0, W0, W0);
    endcase
    return t;
  endfunction

  function automatic logic elem_down(input logic [1:0] m, input logic [2:0] e);
    elem_t t;
    t = elem_info(m, e);
    return t.down;
  endfunction

  function automatic logic [DATA_W-1:0] bg_word(input logic v, input logic [DATA_W-1:0] b);
    return v ? ~b : b;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [1:0]        state;
  logic              drain_cnt;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] bg_q;
  logic [2:0]        elem;
  logic [1:0]        op_idx;
  logic [ADDR_W-1:0] addr_cnt;

  elem_t             cur;
  logic [1:0]        cur_op;
  logic              at_term;
  logic              nxt_down;
  logic              accept;

  always_comb begin
    cur      = elem_info(mode_q, elem);
    cur_op   = cur.ops[{op_idx, 1'b0} +: 2];
    at_term  = cur.down ? (addr_cnt == '0) : (addr_cnt == ADDR_MAX);
    nxt_down = elem_down(mode_q, elem + 3'd1);
    accept   = (state == S_IDLE) && bus.start;
  end

  // Sequencer: counters, FSM and registered SRAM strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      drain_cnt <= 1'b0;
      mode_q    <= '0;
      bg_q      <= '0;
      elem      <= '0;
      op_idx    <= '0;
      addr_cnt  <= '0;
      bus.addr  <= '0;
      bus.wdata <= '0;
      bus.we    <= 1'b0;
      bus.re    <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      bus.addr  <= '0;
      bus.wdata <= '0;
      bus.we    <= 1'b0;
      bus.re    <= 1'b0;
      bus.done  <= 1'b0;
      case (state)
        S_IDLE: begin
          bus.busy <= 1'b0;
          if (bus.start) begin
            mode_q   <= bus.mode;
            bg_q     <= bus.bg;
            elem     <= '0;
            op_idx   <= '0;
            addr_cnt <= '0;
            // Illegal mode enters the last drain step so done follows one
            // cycle later without ever touching memory.
            if (bus.mode == 2'd3) begin
              state     <= S_DRAIN;
              drain_cnt <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          bus.busy  <= 1'b1;
          bus.addr  <= addr_cnt;
          bus.we    <= cur_op[1];
          bus.re    <= ~cur_op[1];
          bus.wdata <= cur_op[1] ? bg_word(cur_op[0], bg_q) : '0;
          if (op_idx == cur.last_op) begin
            op_idx <= '0;
            if (at_term) begin
              if (cur.last_elem) begin
                state     <= S_DRAIN;
                drain_cnt <= 1'b0;
              end else begin
                elem     <= elem + 3'd1;
                addr_cnt <= nxt_down ? ADDR_MAX : '0;
              end
            end else begin
              addr_cnt <= cur.down ? addr_cnt - ADDR_W'(1) : addr_cnt + ADDR_W'(1);
            end
          end else begin
            op_idx <= op_idx + 2'd1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= S_DONE;
          end else begin
            bus.busy  <= 1'b1;
            drain_cnt <= 1'b1;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  // Compare pipe, stage p0: entry issued alongside the op; writes are bubbles
  logic              vld_p0, vld_p1;
  logic [DATA_W-1:0] exp_p0, exp_p1;
  logic [ADDR_W-1:0] addr_p0, addr_p1;
  logic [2:0]        elem_p0, elem_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= (state == S_RUN) && !cur_op[1];
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    exp_p0  <= bg_word(cur_op[0], bg_q);
    addr_p0 <= addr_cnt;
    elem_p0 <= elem;
    // Stage p1: SRAM samples the read; rdata is valid at the next edge
    exp_p1  <= exp_p0;
    addr_p1 <= addr_p0;
    elem_p1 <= elem_p0;
  end

  // Stage p2: compare against rdata and update sticky status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.fail       <= 1'b0;
      bus.fail_addr  <= '0;
      bus.fail_elem  <= '0;
      bus.fail_count <= '0;
    end else if (accept) begin
      bus.fail       <= (bus.mode == 2'd3);
      bus.fail_addr  <= '0;
      bus.fail_elem  <= '0;
      bus.fail_count <= '0;
    end else if (vld_p1 && (bus.rdata != exp_p1)) begin
      bus.fail       <= 1'b1;
      bus.fail_count <= sat_inc(bus.fail_count);
      if (!bus.fail) begin
        bus.fail_addr <= addr_p1;
        bus.fail_elem <= elem_p1;
      end
    end
  end

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Directed testbench for march_bist_ctrl: a behavioural SRAM with an
// optional bit0 stuck-at-1 fault, an op recorder, and one task per scenario.
module tb_march_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  march_bist_if #(.ADDR_W(8), .DATA_W(4), .CNT_W(8)) bif ();
  march_bist_if #(.ADDR_W(3), .DATA_W(4), .CNT_W(2)) sif ();

  march_bist_ctrl #(.ADDR_W(8), .DATA_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.slave));
  march_bist_ctrl #(.ADDR_W(3), .DATA_W(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(sif.slave));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main SRAM with optional stuck-at-1 on bit0 at one address
  logic [3:0] mem [256];
  logic       flt_en = 1'b0;
  logic [7:0] flt_a = 8'h00;
  always @(posedge clk) begin
    if (bif.we) mem[bif.addr] <= bif.wdata;
    if (bif.re) bif.rdata <= mem[bif.addr] | ((flt_en && bif.addr == flt_a) ? 4'h1 : 4'h0);
  end

  // Small SRAM: bit0 stuck-at-1 at every address
  logic [3:0] smem [8];
  always @(posedge clk) begin
    if (sif.we) smem[sif.addr] <= sif.wdata;
    if (sif.re) sif.rdata <= smem[sif.addr] | 4'h1;
  end

  typedef struct packed {
    logic       we;
    logic       re;
    logic [7:0] addr;
    logic [3:0] wdata;
    int         cyc;
  } op_t;

  op_t q[$];
  int  done_n = 0;
  int  done_cyc = 0;
  int  busy_n = 0;
  int  both_n = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (bif.we || bif.re) q.push_back('{bif.we, bif.re, bif.addr, bif.wdata, cyc});
      if (bif.done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (bif.busy) busy_n++;
      if (bif.we && bif.re) both_n++;
    end
  end

  task automatic clear_mon();
    q.delete();
    done_n = 0;
    busy_n = 0;
    both_n = 0;
  endtask

  task automatic run_alg(input logic [1:0] m, input logic [3:0] b, input int limit,
                         output int e0, output bit to);
    clear_mon();
    @(posedge clk); #1;
    bif.start = 1'b1; bif.mode = m; bif.bg = b;
    @(posedge clk); #1;
    e0 = cyc;
    // Changing mode/bg after the accepted start must not matter
    bif.start = 1'b0; bif.mode = 2'd1; bif.bg = ~b;
    to = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (done_n != 0) begin
        to = 1'b0;
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bif.start = 1'b0; bif.mode = 2'd0; bif.bg = 4'h0;
    sif.start = 1'b0; sif.mode = 2'd0; sif.bg = 4'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bif.addr, bif.wdata, bif.we, bif.re, bif.busy, bif.done, bif.fail,
         bif.fail_addr, bif.fail_elem, bif.fail_count} !== 38'h0) begin
      errors++;
      $display("FAIL reset_main: got addr=%0h wdata=%0h we=%0b re=%0b busy=%0b done=%0b fail=%0b cnt=%0d expected all 0",
               bif.addr, bif.wdata, bif.we, bif.re, bif.busy, bif.done, bif.fail, bif.fail_count);
    end
    checks++;
    if ({sif.addr, sif.wdata, sif.we, sif.re, sif.busy, sif.done, sif.fail,
         sif.fail_addr, sif.fail_elem, sif.fail_count} !== 21'h0) begin
      errors++;
      $display("FAIL reset_small: got busy=%0b done=%0b fail=%0b cnt=%0d expected all 0",
               sif.busy, sif.done, sif.fail, sif.fail_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mats_plus();
    int e0; bit to; int bad;
    run_alg(2'd0, 4'h0, 2000, e0, to);
    checks++;
    if (to) begin errors++; $display("FAIL mats_timeout: got no done expected done"); end
    checks++;
    if (q.size() != 1280) begin errors++; $display("FAIL mats_ops: got %0d expected 1280", q.size()); end
    checks++;
    if (done_cyc != e0 + 1282) begin errors++; $display("FAIL mats_done_cyc: got %0d expected %0d", done_cyc - e0, 1282); end
    checks++;
    if (done_n != 1) begin errors++; $display("FAIL mats_done_width: got %0d expected 1", done_n); end
    checks++;
    if (busy_n != 1281) begin errors++; $display("FAIL mats_busy_cycles: got %0d expected 1281", busy_n); end
    checks++;
    if (q[0].cyc != e0 + 1) begin errors++; $display("FAIL mats_first_op_cyc: got %0d expected 1", q[0].cyc - e0); end
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (!(q[i].we && !q[i].re && q[i].addr == 8'(i) && q[i].wdata == 4'h0)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mats_w0_seq: got %0d bad ops expected 0", bad); end
    checks++;
    if ({q[256].we, q[256].re, q[256].addr, q[257].we, q[257].wdata} != {1'b0, 1'b1, 8'h00, 1'b1, 4'hF}) begin
      errors++;
      $display("FAIL mats_elem1_start: got re=%0b addr=%0h we=%0b wdata=%0h expected re=1 addr=0 we=1 wdata=f",
               q[256].re, q[256].addr, q[257].we, q[257].wdata);
    end
    checks++;
    if ({q[1278].re, q[1278].addr, q[1279].we, q[1279].addr, q[1279].wdata} != {1'b1, 8'h00, 1'b1, 8'h00, 4'h0}) begin
      errors++;
      $display("FAIL mats_last_ops: got addr=%0h/%0h wdata=%0h expected 0/0 wdata=0", q[1278].addr, q[1279].addr, q[1279].wdata);
    end
    checks++;
    if ({bif.fail, bif.fail_count} != 9'h0) begin
      errors++; $display("FAIL mats_status: got fail=%0b cnt=%0d expected 0 0", bif.fail, bif.fail_count);
    end
    checks++;
    if (both_n != 0) begin errors++; $display("FAIL mats_we_re_both: got %0d expected 0", both_n); end
  endtask

  task automatic test_march_lr();
    int e0; bit to; int bad;
    run_alg(2'd2, 4'h0, 5000, e0, to);
    checks++;
    if (to) begin errors++; $display("FAIL lr_timeout: got no done expected done"); end
    checks++;
    if (q.size() != 3584) begin errors++; $display("FAIL lr_ops: got %0d expected 3584", q.size()); end
    checks++;
    if (done_cyc != e0 + 3586) begin errors++; $display("FAIL lr_done_cyc: got %0d expected 3586", done_cyc - e0); end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (!(q[256 + 2*i].re && q[256 + 2*i].addr == 8'(255 - i))) bad++;
      if (!(q[257 + 2*i].we && q[257 + 2*i].addr == 8'(255 - i) && q[257 + 2*i].wdata == 4'hF)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL lr_elem1_down: got %0d bad ops expected 0", bad); end
    checks++;
    if ({q[768].re, q[768].wdata, q[769].we, q[769].wdata, q[770].re, q[770].wdata, q[771].we, q[771].wdata,
         q[771].addr} != {1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 4'hF, 8'h00}) begin
      errors++;
      $display("FAIL lr_elem2_ops: got %0b%0b%0b%0b wdata %0h %0h addr %0h expected re,we,re,we wdata 0 f addr 0",
               q[768].re, q[769].we, q[770].re, q[771].we, q[769].wdata, q[771].wdata, q[771].addr);
    end
    checks++;
    if ({q[3583].re, q[3583].addr} != {1'b1, 8'hFF}) begin
      errors++; $display("FAIL lr_last_op: got re=%0b addr=%0h expected re=1 addr=ff", q[3583].re, q[3583].addr);
    end
    checks++;
    if ({bif.fail, bif.fail_count} != 9'h0) begin
      errors++; $display("FAIL lr_status: got fail=%0b cnt=%0d expected 0 0", bif.fail, bif.fail_count);
    end
  endtask

  task automatic test_cminus_fault();
    int e0; bit to;
    flt_en = 1'b1; flt_a = 8'h5A;
    run_alg(2'd1, 4'h0, 4000, e0, to);
    flt_en = 1'b0;
    checks++;
    if (to) begin errors++; $display("FAIL cm_timeout: got no done expected done"); end
    checks++;
    if (q.size() != 2560) begin errors++; $display("FAIL cm_ops: got %0d expected 2560", q.size()); end
    checks++;
    if (bif.fail !== 1'b1) begin errors++; $display("FAIL cm_fail: got %0b expected 1", bif.fail); end
    checks++;
    if (bif.fail_addr !== 8'h5A) begin errors++; $display("FAIL cm_fail_addr: got %0h expected 5a", bif.fail_addr); end
    checks++;
    if (bif.fail_elem !== 3'd1) begin errors++; $display("FAIL cm_fail_elem: got %0d expected 1", bif.fail_elem); end
    checks++;
    if (bif.fail_count !== 8'd3) begin errors++; $display("FAIL cm_fail_count: got %0d expected 3", bif.fail_count); end
  endtask

  task automatic test_illegal_mode();
    int e0; bit to;
    run_alg(2'd3, 4'h0, 20, e0, to);
    checks++;
    if (to) begin errors++; $display("FAIL ill_timeout: got no done expected done"); end
    checks++;
    if (done_cyc != e0 + 1) begin errors++; $display("FAIL ill_done_cyc: got %0d expected 1", done_cyc - e0); end
    checks++;
    if ({bif.fail, bif.fail_count, bif.fail_addr, bif.fail_elem} != {1'b1, 8'd0, 8'h00, 3'd0}) begin
      errors++;
      $display("FAIL ill_status: got fail=%0b cnt=%0d addr=%0h elem=%0d expected 1 0 0 0",
               bif.fail, bif.fail_count, bif.fail_addr, bif.fail_elem);
    end
    checks++;
    if (q.size() != 0 || busy_n != 0) begin
      errors++; $display("FAIL ill_no_access: got ops=%0d busy=%0d expected 0 0", q.size(), busy_n);
    end
  endtask

  task automatic test_background();
    int e0; bit to;
    run_alg(2'd0, 4'b0101, 2000, e0, to);
    checks++;
    if (to || q.size() != 1280) begin errors++; $display("FAIL bg_ops: got %0d expected 1280", q.size()); end
    checks++;
    if ({q[0].we, q[0].wdata, q[256].re, q[256].wdata, q[257].we, q[257].wdata, q[1279].wdata}
        != {1'b1, 4'h5, 1'b1, 4'h0, 1'b1, 4'hA, 4'h5}) begin
      errors++;
      $display("FAIL bg_wdata: got %0h %0h %0h %0h expected 5 0 a 5", q[0].wdata, q[256].wdata, q[257].wdata, q[1279].wdata);
    end
    checks++;
    if ({bif.fail, bif.fail_count} != 9'h0) begin
      errors++; $display("FAIL bg_status: got fail=%0b cnt=%0d expected 0 0", bif.fail, bif.fail_count);
    end
  endtask

  task automatic test_start_busy_reset();
    int e0; bit to; int bad; int j;
    clear_mon();
    @(posedge clk); #1;
    bif.start = 1'b1; bif.mode = 2'd0; bif.bg = 4'h0;
    @(posedge clk); #1;
    bif.start = 1'b0;
    for (int i = 0; i < 200 && q.size() < 100; i++) begin @(posedge clk); #1; end
    bif.start = 1'b1; bif.mode = 2'd1; bif.bg = 4'hF;
    @(posedge clk); #1;
    bif.start = 1'b0;
    for (int i = 0; i < 600 && q.size() < 500; i++) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bif.addr, bif.wdata, bif.we, bif.re, bif.busy, bif.done, bif.fail,
         bif.fail_addr, bif.fail_elem, bif.fail_count} !== 38'h0) begin
      errors++;
      $display("FAIL async_reset: got addr=%0h we=%0b re=%0b busy=%0b expected all 0", bif.addr, bif.we, bif.re, bif.busy);
    end
    bad = (q.size() < 500) ? 1 : 0;
    for (int k = 0; k < 500; k++) begin
      if (k < 256) begin
        if (!(q[k].we && q[k].addr == 8'(k) && q[k].wdata == 4'h0)) bad++;
      end else begin
        j = k - 256;
        if (j % 2 == 0) begin
          if (!(q[k].re && q[k].addr == 8'(j / 2) && q[k].wdata == 4'h0)) bad++;
        end else begin
          if (!(q[k].we && q[k].addr == 8'(j / 2) && q[k].wdata == 4'hF)) bad++;
        end
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL busy_start_seq: got %0d bad ops expected 0", bad); end
    checks++;
    if (done_n != 0) begin errors++; $display("FAIL reset_no_done: got %0d expected 0", done_n); end
    @(posedge clk); #1;
    checks++;
    if ({bif.busy, bif.we, bif.re} !== 3'b000) begin
      errors++; $display("FAIL reset_held: got busy=%0b we=%0b re=%0b expected 0", bif.busy, bif.we, bif.re);
    end
    rst_n = 1'b1;
    run_alg(2'd0, 4'h0, 2000, e0, to);
    checks++;
    if (to || q.size() != 1280 || done_cyc != e0 + 1282) begin
      errors++; $display("FAIL rerun_after_reset: got ops=%0d done=%0d expected 1280 1282", q.size(), done_cyc - e0);
    end
    checks++;
    if (bif.fail !== 1'b0) begin errors++; $display("FAIL rerun_fail: got %0b expected 0", bif.fail); end
  endtask

  task automatic test_saturation();
    bit seen;
    @(posedge clk); #1;
    sif.start = 1'b1; sif.mode = 2'd0; sif.bg = 4'h0;
    @(posedge clk); #1;
    sif.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      if (sif.done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL sat_timeout: got no done expected done"); end
    checks++;
    if (sif.fail_count !== 2'd3) begin errors++; $display("FAIL sat_count: got %0d expected 3", sif.fail_count); end
    checks++;
    if ({sif.fail, sif.fail_addr, sif.fail_elem} !== {1'b1, 3'd0, 3'd1}) begin
      errors++; $display("FAIL sat_first: got fail=%0b addr=%0d elem=%0d expected 1 0 1", sif.fail, sif.fail_addr, sif.fail_elem);
    end
  endtask

  initial begin
    test_reset();
    test_mats_plus();
    test_march_lr();
    test_cminus_fault();
    test_illegal_mode();
    test_background();
    test_start_busy_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
